io_write_port_bank: RTL and testbench

IO_WRITE_PORT_BANK -- requirements
Module: io_write_port_bank

---
 rtl/io_write_port_bank.sv | 108 ++++++++++
 tb/tb_io_write_port_bank.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/io_write_port_bank.sv
// io_write_port_bank
//   A bank of PORT_COUNT independent CPU write ports. Each port buffers CPU
//   writes in a small FIFO and presents them to an external consumer through
//   a valid/ready handshake.
//
// Parameters
//   WORD_WIDTH      width of one I/O word
//   PORT_COUNT      number of independent write ports
//   FIFO_DEPTH      words per port (power of two, >= 2)
//   FIFO_ADDR_WIDTH log2(FIFO_DEPTH)
//   EF_MARGIN       slots held back for writes already in flight when the
//                   CPU samples io_out_EF
//
// Ports
//   clock, reset    rising-edge clock; asynchronous active-high reset
//   io_wren         per-port CPU write enable
//   io_out          per-port CPU write data, port p at [p*WORD_WIDTH +: WORD_WIDTH]
//   io_out_EF       per-port registered "almost full" flag back to the CPU
//   ext_valid       per-port head word present
//   ext_ready       per-port consumer accepts the head word
//   ext_data        per-port head word, same packing as io_out
//   overflow        sticky per-port flag: a write arrived while full
//   overflow_clear  per-port clear for overflow (a new overflow wins)
module io_write_port_bank #(
  parameter int unsigned WORD_WIDTH      = 36,
  parameter int unsigned PORT_COUNT      = 2,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned FIFO_ADDR_WIDTH = 2,
  parameter int unsigned EF_MARGIN       = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [PORT_COUNT-1:0]            io_wren,
  input  logic [WORD_WIDTH*PORT_COUNT-1:0] io_out,
  output logic [PORT_COUNT-1:0]            io_out_EF,
  output logic [PORT_COUNT-1:0]            ext_valid,
  input  logic [PORT_COUNT-1:0]            ext_ready,
  output logic [WORD_WIDTH*PORT_COUNT-1:0] ext_data,
  output logic [PORT_COUNT-1:0]            overflow,
  input  logic [PORT_COUNT-1:0]            overflow_clear
);

  localparam int unsigned CNT_W    = FIFO_ADDR_WIDTH + 1;
  localparam int unsigned EF_LEVEL = FIFO_DEPTH - EF_MARGIN;

  localparam logic [CNT_W-1:0] DEPTH_C    = FIFO_DEPTH[CNT_W-1:0];
  localparam logic [CNT_W-1:0] EF_LEVEL_C = EF_LEVEL[CNT_W-1:0];

  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
    logic [WORD_WIDTH-1:0]      storage [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0]      wdata;
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       ef_q, ef_d;
    logic                       ovf_q, ovf_d;
    logic                       full, enq, deq;

    assign wdata = io_out[p*WORD_WIDTH +: WORD_WIDTH];

    always_comb begin
      // Acceptance looks only at the pre-edge count, so a write arriving while
      // full is dropped even if a dequeue frees a slot on the same edge.
      full     = (count_q == DEPTH_C);
      enq      = io_wren[p] && !full;
      deq      = (count_q != '0) && ext_ready[p];
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = wr_ptr_q + 1'b1;
      if (deq) rd_ptr_d = rd_ptr_q + 1'b1;
      if (enq && !deq) count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;
      ef_d = (count_d >= EF_LEVEL_C);
      // A new overflow takes priority over a clear in the same cycle.
      if (io_wren[p] && full) ovf_d = 1'b1;
      else if (overflow_clear[p]) ovf_d = 1'b0;
      else ovf_d = ovf_q;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        ef_q     <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        ef_q     <= ef_d;
        ovf_q    <= ovf_d;
      end
    end

    // Storage is deliberately not reset; ext_data is meaningless while empty.
    always_ff @(posedge clock) begin
      if (enq) storage[wr_ptr_q] <= wdata;
    end

    assign ext_valid[p]                           = (count_q != '0);
    assign ext_data[p*WORD_WIDTH +: WORD_WIDTH]   = storage[rd_ptr_q];
    assign io_out_EF[p]                           = ef_q;
    assign overflow[p]                            = ovf_q;
  end

endmodule

// File: tb/tb_io_write_port_bank.sv
// Directed testbench for io_write_port_bank (WORD_WIDTH=36, PORT_COUNT=2,
// FIFO_DEPTH=4, EF_MARGIN=1). Inputs change 1ns after each rising edge and
// outputs are checked at that same point, well away from the next edge.
module tb_io_write_port_bank;

  logic        clock;
  logic        reset;
  logic [1:0]  io_wren;
  logic [71:0] io_out;
  logic [1:0]  io_out_EF;
  logic [1:0]  ext_valid;
  logic [1:0]  ext_ready;
  logic [71:0] ext_data;
  logic [1:0]  overflow;
  logic [1:0]  overflow_clear;

  logic [35:0] d0, d1;
  logic [35:0] q0, q1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  assign io_out = {d1, d0};
  assign q0     = ext_data[35:0];
  assign q1     = ext_data[71:36];

  io_write_port_bank #(
    .WORD_WIDTH(36),
    .PORT_COUNT(2),
    .FIFO_DEPTH(4),
    .FIFO_ADDR_WIDTH(2),
    .EF_MARGIN(1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_wren(io_wren),
    .io_out(io_out),
    .io_out_EF(io_out_EF),
    .ext_valid(ext_valid),
    .ext_ready(ext_ready),
    .ext_data(ext_data),
    .overflow(overflow),
    .overflow_clear(overflow_clear)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; io_wren = '0; ext_ready = '0; overflow_clear = '0;
    d0 = '0; d1 = '0;
    #3;
    check_eq("rst_valid", 64'(ext_valid), 64'h0);
    check_eq("rst_ef", 64'(io_out_EF), 64'h0);
    check_eq("rst_ovf", 64'(overflow), 64'h0);
    step();
    reset = 1'b0;

    // Fill and flag: three writes, consumer stalled.
    io_wren = 2'b01; d0 = 36'h1;
    step();
    check_eq("fill_valid1", 64'(ext_valid[0]), 64'h1);
    check_eq("fill_ef1", 64'(io_out_EF[0]), 64'h0);
    check_eq("fill_data1", 64'(q0), 64'h1);
    d0 = 36'h2; step();
    check_eq("fill_ef2", 64'(io_out_EF[0]), 64'h0);
    d0 = 36'h3; step();
    check_eq("fill_ef3", 64'(io_out_EF[0]), 64'h1);
    check_eq("fill_data3", 64'(q0), 64'h1);

    // Overflow: fourth word fills, fifth is dropped.
    d0 = 36'h4; step();
    check_eq("full_ovf", 64'(overflow[0]), 64'h0);
    d0 = 36'h5; step();
    check_eq("ovf_set", 64'(overflow[0]), 64'h1);
    check_eq("ovf_ef", 64'(io_out_EF[0]), 64'h1);
    io_wren = '0; ext_ready = 2'b01;
    for (int i = 1; i <= 4; i++) begin
      check_eq("drain_valid", 64'(ext_valid[0]), 64'h1);
      check_eq("drain_data", 64'(q0), 64'(i));
      step();
    end
    check_eq("drain_empty", 64'(ext_valid[0]), 64'h0);
    check_eq("drain_ef", 64'(io_out_EF[0]), 64'h0);
    ext_ready = '0; overflow_clear = 2'b01; step();
    overflow_clear = '0;
    check_eq("ovf_clr0", 64'(overflow[0]), 64'h0);

    // Full with simultaneous write and read.
    io_wren = 2'b01;
    for (int i = 0; i < 4; i++) begin
      d0 = 36'h11 + 36'(i);
      step();
    end
    d0 = 36'h15; ext_ready = 2'b01; step();
    check_eq("wr_rd_ovf", 64'(overflow[0]), 64'h1);
    check_eq("wr_rd_ef", 64'(io_out_EF[0]), 64'h1);
    check_eq("wr_rd_data", 64'(q0), 64'h12);
    io_wren = '0;
    for (int i = 0; i < 3; i++) begin
      check_eq("wr_rd_drain", 64'(q0), 64'h12 + 64'(i));
      step();
    end
    check_eq("wr_rd_empty", 64'(ext_valid[0]), 64'h0);
    overflow_clear = 2'b01; step();
    overflow_clear = '0;

    // Wrap-around streaming: 10 words with the consumer always ready.
    io_wren = 2'b01; ext_ready = 2'b01;
    for (int i = 0; i < 10; i++) begin
      d0 = 36'hA0 + 36'(i);
      step();
      check_eq("stream_valid", 64'(ext_valid[0]), 64'h1);
      check_eq("stream_data", 64'(q0), 64'hA0 + 64'(i));
      check_eq("stream_ef", 64'(io_out_EF[0]), 64'h0);
      check_eq("stream_ovf", 64'(overflow[0]), 64'h0);
    end
    io_wren = '0; step();
    check_eq("stream_empty", 64'(ext_valid[0]), 64'h0);

    // Port independence: port1 overflows while port0 streams.
    ext_ready = 2'b01; io_wren = 2'b11;
    for (int i = 0; i < 5; i++) begin
      d0 = 36'hB0 + 36'(i);
      d1 = 36'hC0 + 36'(i);
      step();
      check_eq("ind_p0_data", 64'(q0), 64'hB0 + 64'(i));
    end
    check_eq("ind_ovf", 64'(overflow), 64'h2);
    check_eq("ind_ef", 64'(io_out_EF), 64'h2);
    check_eq("ind_p1_data", 64'(q1), 64'hC0);
    io_wren = 2'b10; overflow_clear = 2'b10; d1 = 36'hC5; step();
    check_eq("clr_vs_set", 64'(overflow[1]), 64'h1);
    check_eq("p0_drained", 64'(ext_valid[0]), 64'h0);
    io_wren = '0; step();
    overflow_clear = '0;
    check_eq("clr_alone", 64'(overflow[1]), 64'h0);
    ext_ready = 2'b10;
    for (int i = 0; i < 4; i++) begin
      check_eq("p1_drain", 64'(q1), 64'hC0 + 64'(i));
      step();
    end
    check_eq("p1_empty", 64'(ext_valid[1]), 64'h0);

    // Reset mid-operation.
    ext_ready = '0; io_wren = 2'b11;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) io_wren = 2'b10;
      d0 = 36'hD0 + 36'(i);
      d1 = 36'hE0 + 36'(i);
      step();
    end
    io_wren = '0;
    check_eq("pre_rst_valid", 64'(ext_valid), 64'h3);
    check_eq("pre_rst_p0", 64'(q0), 64'hD0);
    check_eq("pre_rst_ovf", 64'(overflow), 64'h2);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid", 64'(ext_valid), 64'h0);
    check_eq("arst_ef", 64'(io_out_EF), 64'h0);
    check_eq("arst_ovf", 64'(overflow), 64'h0);
    #1 reset = 1'b0;
    io_wren = 2'b01; d0 = 36'hF0; step();
    io_wren = '0;
    check_eq("post_rst_valid", 64'(ext_valid), 64'h1);
    check_eq("post_rst_data", 64'(q0), 64'hF0);
    check_eq("post_rst_ef", 64'(io_out_EF), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
